// File: rtl/avg_var.sv
// avg_var: windowed streaming mean / population variance over 2^LOG2N samples.
// Accepts 8-bit unsigned samples on a valid/ready handshake and emits one
// {avg[7:0], var[15:0]} word per non-overlapping window.
module avg_var #(
  parameter int unsigned LOG2N = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idata_vld,
  output logic        idata_rdy,
  input  logic [7:0]  idata,
  output logic        odata_vld,
  input  logic        odata_rdy,
  output logic [23:0] odata
);

  localparam int unsigned CW = LOG2N;
  localparam int unsigned SW = 8 + LOG2N;
  localparam int unsigned QW = 16 + LOG2N;
  localparam int unsigned DW = 2 * SW;

  localparam logic [CW-1:0] LAST = '1;

  logic [CW-1:0] cnt;
  logic [SW-1:0] sum;
  logic [QW-1:0] sq;

  logic          accept_c;
  logic          close_c;
  logic [SW-1:0] sum_nxt_c;
  logic [QW-1:0] sq_nxt_c;
  logic [DW-1:0] diff_c;
  logic [7:0]    avg_c;
  logic [15:0]   var_c;

  // Only the window-closing sample stalls, and only while a result is pending.
  always_comb begin
    idata_rdy = !((cnt == LAST) && odata_vld);
  end

  // Running totals including the current sample, and the window result.
  always_comb begin
    accept_c  = idata_vld && idata_rdy;
    close_c   = accept_c && (cnt == LAST);
    sum_nxt_c = sum + SW'(idata);
    sq_nxt_c  = sq + QW'(16'(idata) * 16'(idata));
    // N*Q - S*S is non-negative for any sample set; full width avoids overflow.
    diff_c    = (DW'(sq_nxt_c) << LOG2N) - (DW'(sum_nxt_c) * DW'(sum_nxt_c));
    avg_c     = 8'(sum_nxt_c >> LOG2N);
    var_c     = 16'(diff_c >> (2 * LOG2N));
  end

  // Sample counter and accumulators; cleared when a window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sum <= '0;
      sq  <= '0;
    end else if (close_c) begin
      cnt <= '0;
      sum <= '0;
      sq  <= '0;
    end else if (accept_c) begin
      cnt <= cnt + CW'(1);
      sum <= sum_nxt_c;
      sq  <= sq_nxt_c;
    end
  end

  // Output register: a new result takes priority over draining the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      odata_vld <= 1'b0;
      odata     <= '0;
    end else if (close_c) begin
      odata_vld <= 1'b1;
      odata     <= {avg_c, var_c};
    end else if (odata_rdy) begin
      odata_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avg_var.sv
// tb_avg_var: directed and randomized-stall checks for avg_var with N=4.
module tb_avg_var;

  logic        clk = 1'b0;
  logic        rst;
  logic        idata_vld;
  logic        idata_rdy;
  logic [7:0]  idata;
  logic        odata_vld;
  logic        odata_rdy;
  logic [23:0] odata;

  int total = 0;
  int bad   = 0;
  logic [23:0] got_q[$];

  avg_var #(.LOG2N(2)) dut (
    .clk(clk),
    .rst(rst),
    .idata_vld(idata_vld),
    .idata_rdy(idata_rdy),
    .idata(idata),
    .odata_vld(odata_vld),
    .odata_rdy(odata_rdy),
    .odata(odata)
  );

  always #5 clk = ~clk;

  // Record every result handshake; inputs only change at posedge+1.
  always @(negedge clk) begin
    if (!rst && odata_vld && odata_rdy) got_q.push_back(odata);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted; reports stall cycles.
  task automatic send(input logic [7:0] x, output int stalls);
    idata     = x;
    idata_vld = 1'b1;
    stalls    = 0;
    while (!idata_rdy && stalls < 200) begin
      step();
      stalls++;
    end
    if (!idata_rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout got idata_rdy=%b exp=1", idata_rdy);
    end
    step();
    idata_vld = 1'b0;
    idata     = 8'h00;
  endtask

  task automatic test_reset();
    int st;
    total++;
    if (idata_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", idata_rdy); end
    total++;
    if (odata_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", odata_vld); end
    total++;
    if (odata !== 24'h0) begin bad++; $display("FAIL reset_odata got=%h exp=000000", odata); end
    rst = 1'b0;
    send(8'd7, st);
    total++;
    if (st != 0) begin bad++; $display("FAIL reset_first_accept got stalls=%0d exp=0", st); end
    repeat (3) send(8'd7, st);
    total++;
    if (odata_vld !== 1'b1 || odata !== 24'h070000)
      begin bad++; $display("FAIL reset_first_window got vld=%b odata=%h exp vld=1 odata=070000", odata_vld, odata); end
    step();
  endtask

  task automatic test_basic();
    logic [7:0]  smp [4][4];
    logic [23:0] expv [4];
    int st;
    smp[0] = '{8'd10, 8'd20, 8'd30, 8'd40};   expv[0] = 24'h19007D;
    smp[1] = '{8'd0, 8'd0, 8'd255, 8'd255};   expv[1] = 24'h7F3F80;
    smp[2] = '{8'd255, 8'd255, 8'd255, 8'd255}; expv[2] = 24'hFF0000;
    smp[3] = '{8'd1, 8'd2, 8'd3, 8'd4};       expv[3] = 24'h020001;
    odata_rdy = 1'b1;
    for (int v = 0; v < 4; v++) begin
      got_q.delete();
      for (int k = 0; k < 3; k++) send(smp[v][k], st);
      total++;
      if (odata_vld !== 1'b0) begin bad++; $display("FAIL basic_early_vld[%0d] got=%b exp=0", v, odata_vld); end
      send(smp[v][3], st);
      total++;
      if (odata_vld !== 1'b1 || odata !== expv[v])
        begin bad++; $display("FAIL basic_result[%0d] got vld=%b odata=%h exp vld=1 odata=%h", v, odata_vld, odata, expv[v]); end
      step();
      total++;
      if (odata_vld !== 1'b0) begin bad++; $display("FAIL basic_drain[%0d] got vld=%b exp=0", v, odata_vld); end
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL basic_count[%0d] got=%0d exp=1", v, got_q.size()); end
    end
  endtask

  task automatic test_backpressure();
    int st;
    int st_sum;
    got_q.delete();
    odata_rdy = 1'b0;
    send(8'd1, st); send(8'd2, st); send(8'd3, st); send(8'd4, st);
    st_sum = 0;
    send(8'd10, st); st_sum += st;
    send(8'd20, st); st_sum += st;
    send(8'd30, st); st_sum += st;
    total++;
    if (st_sum != 0) begin bad++; $display("FAIL bp_open_stalls got=%0d exp=0", st_sum); end
    idata = 8'd40;
    idata_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (idata_rdy !== 1'b0 || odata_vld !== 1'b1 || odata !== 24'h020001)
        begin bad++; $display("FAIL bp_hold[%0d] got rdy=%b vld=%b odata=%h exp rdy=0 vld=1 odata=020001", k, idata_rdy, odata_vld, odata); end
      step();
    end
    odata_rdy = 1'b1;
    send(8'd40, st);
    total++;
    if (st != 1) begin bad++; $display("FAIL bp_close_stalls got=%0d exp=1", st); end
    total++;
    if (odata_vld !== 1'b1 || odata !== 24'h19007D)
      begin bad++; $display("FAIL bp_new_result got vld=%b odata=%h exp vld=1 odata=19007d", odata_vld, odata); end
    step();
    total++;
    if (got_q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", got_q.size()); end
    else begin
      total++;
      if (got_q[0] !== 24'h020001 || got_q[1] !== 24'h19007D)
        begin bad++; $display("FAIL bp_order got=%h,%h exp=020001,19007d", got_q[0], got_q[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] smp [12];
    int st;
    int st_sum;
    time t0;
    smp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
    got_q.delete();
    odata_rdy = 1'b1;
    st_sum = 0;
    t0 = $time;
    for (int k = 0; k < 12; k++) begin
      send(smp[k], st);
      st_sum += st;
      if (k == 7) begin
        total++;
        if (odata_vld !== 1'b1 || odata !== 24'hFF0000)
          begin bad++; $display("FAIL b2b_mid got vld=%b odata=%h exp vld=1 odata=ff0000", odata_vld, odata); end
      end
    end
    total++;
    if (st_sum != 0 || ($time - t0) != 120)
      begin bad++; $display("FAIL b2b_rate got stalls=%0d time=%0t exp stalls=0 time=120", st_sum, $time - t0); end
    step();
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    else begin
      total++;
      if (got_q[0] !== 24'h020001 || got_q[1] !== 24'hFF0000 || got_q[2] !== 24'h7F3F80)
        begin bad++; $display("FAIL b2b_values got=%h,%h,%h exp=020001,ff0000,7f3f80", got_q[0], got_q[1], got_q[2]); end
    end
  endtask

  task automatic test_reset_mid();
    int st;
    odata_rdy = 1'b0;
    send(8'd1, st); send(8'd2, st); send(8'd3, st); send(8'd4, st);
    send(8'd50, st); send(8'd60, st);
    rst = 1'b1;
    #1;
    total++;
    if (odata_vld !== 1'b0 || odata !== 24'h0 || idata_rdy !== 1'b1)
      begin bad++; $display("FAIL rstmid_async got vld=%b odata=%h rdy=%b exp vld=0 odata=000000 rdy=1", odata_vld, odata, idata_rdy); end
    step();
    step();
    total++;
    if (odata_vld !== 1'b0 || odata !== 24'h0 || idata_rdy !== 1'b1)
      begin bad++; $display("FAIL rstmid_held got vld=%b odata=%h rdy=%b exp vld=0 odata=000000 rdy=1", odata_vld, odata, idata_rdy); end
    rst = 1'b0;
    odata_rdy = 1'b1;
    got_q.delete();
    send(8'd10, st); send(8'd20, st); send(8'd30, st); send(8'd40, st);
    total++;
    if (odata_vld !== 1'b1 || odata !== 24'h19007D)
      begin bad++; $display("FAIL rstmid_result got vld=%b odata=%h exp vld=1 odata=19007d", odata_vld, odata); end
    step();
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_random();
    logic [23:0] exp_q[$];
    int win [4];
    int st;
    int waited;
    bit done;
    got_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int s;
          int q;
          repeat ($urandom_range(0, 2)) step();
          win[i % 4] = int'($urandom_range(0, 255));
          send(8'(win[i % 4]), st);
          if (i % 4 == 3) begin
            s = win[0] + win[1] + win[2] + win[3];
            q = win[0]*win[0] + win[1]*win[1] + win[2]*win[2] + win[3]*win[3];
            exp_q.push_back({8'(s / 4), 16'((4*q - s*s) / 16)});
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          odata_rdy = ($urandom_range(0, 3) != 0);
          step();
        end
        odata_rdy = 1'b1;
      end
    join
    waited = 0;
    while (got_q.size() < 100 && waited < 20) begin
      step();
      waited++;
    end
    step();
    total++;
    if (got_q.size() != 100) begin bad++; $display("FAIL rand_count got=%0d exp=100", got_q.size()); end
    for (int k = 0; k < 100 && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== exp_q[k])
        begin bad++; $display("FAIL rand_result[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    idata_vld = 1'b0;
    idata     = 8'h00;
    odata_rdy = 1'b1;
    step();
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avg_var.md
# avg_var

Streaming statistics block. It consumes 8-bit unsigned samples over a valid/ready handshake and groups them into consecutive, non-overlapping windows of 2^LOG2N samples. For each window it emits one 24-bit word holding the window mean and population variance. It sits between a sample producer and a downstream consumer, both using valid/ready flow control.

## Interface
- LOG2N, default 2: log2 of the window length N. Supported range is 1..4; the default gives N=4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- idata_vld  in  1  input sample valid.
- idata_rdy  out  1  block can accept a sample.
- idata  in  8  unsigned input sample.
- odata_vld  out  1  result valid.
- odata_rdy  in  1  consumer accepts the result.
- odata  out  24  result: [23:16] = avg (8 bits), [15:0] = var (16 bits).

## Operation
- A sample is accepted on a rising edge where idata_vld & idata_rdy. idata is ignored at all other times and may be X.
- State held by the block:
  - sample counter cnt, range 0..N-1;
  - running sum S, 8+LOG2N bits;
  - running sum of squares Q, 16+LOG2N bits;
  - output register (odata, odata_vld).
- Each accepted sample x updates S += x and Q += x*x, and increments cnt.
- On the N-th accepted sample (cnt == N-1), using the totals that include that sample:
  - avg = floor(S / N), i.e. S >> LOG2N;
  - var = floor((N*Q - S*S) / N^2), i.e. (N*Q - S*S) >> (2*LOG2N).
  - The intermediate N*Q - S*S is never negative. Compute it at full width: 2*(8+LOG2N) bits.
  - var is the floor of the population variance and always fits in 16 bits (maximum 16256).
  - The result {avg, var} is loaded into the output register, odata_vld is set to 1, and S, Q and cnt clear to 0 in the same edge.
- Output register:
  - When odata_vld=1, odata holds stable until a rising edge with odata_rdy=1. On that edge odata_vld drops to 0, unless a new result loads on the same edge.
  - If the register drains and a new result loads on the same edge, the new result wins and odata_vld stays 1.
- Back-pressure: idata_rdy = !(cnt == N-1 && odata_vld).
  - Samples 1..N-1 of the next window keep being accepted while a result is pending.
  - Only the window-closing sample stalls.
  - idata_rdy has no combinational path from odata_rdy or idata_vld.
- Reset, asserted at any time:
  - cnt, S and Q clear to 0, discarding any partial window;
  - odata_vld clears to 0 and odata to 0;
  - idata_rdy reads 1 while reset is held.

## Timing
- Latency: odata_vld rises on the same clock edge that accepts the window's N-th sample. The result is visible in the cycle after that handshake.
- Throughput: with odata_rdy held at 1, one sample is accepted per cycle with no bubbles, and one result is produced every N accepted samples.
- A result is consumed on the edge where odata_vld & odata_rdy.
- odata_rdy=0 for K cycles delays only the closing sample of the following window, by at most K cycles. No sample or result is ever lost or duplicated.
- Reset release: the first sample can be accepted on the first rising edge after rst deasserts.

## Test plan
- N=4, odata_rdy=1, samples 10,20,30,40 -> a single result one cycle after the 4th accept: avg=25, var=125 (odata=0x19007D).
- Samples 0,0,255,255 -> avg=127, var=16256. Samples 255,255,255,255 -> avg=255, var=0. Samples 1,2,3,4 -> avg=2, var=1 (floor checks).
- Hold odata_rdy=0 after a result, then feed 4 more samples -> the first 3 are accepted, idata_rdy=0 at cnt=3, and odata holds stable. After odata_rdy=1 the pending result drains, the 4th sample is accepted, and the new result appears with no loss.
- Assert rst mid-window after 2 samples, release, feed 10,20,30,40 -> the result is avg=25, var=125 (the partial window was discarded); odata_vld=0 and odata=0 during reset.
- Random idata_vld gaps and random odata_rdy stalls over 400 samples -> exactly 100 results, each matching a software model of floor mean and floor population variance per 4-sample window.
- Drain and load on the same edge: odata_rdy=1 on the edge where the closing sample is accepted -> odata_vld stays 1 and the new value replaces the old.
